// File: rtl/dbus_dmem_resp.sv
// Memory-side responder for the LSU data bus: word-organised RAM with byte-lane
// stores, configurable wait states, flush abort and out-of-range error reporting.
module dbus_dmem_resp #(
    parameter int unsigned DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_w_data_i,
    input  logic        dbus_ld_req_i,
    input  logic        dbus_st_req_i,
    input  logic [1:0]  dbus_st_ops_i,
    output logic [31:0] dbus_r_data_o,
    output logic        dbus_ack_o,
    output logic        dbus_err_o
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] ops, input logic [1:0] lo);
        logic [3:0] be;
        case (ops)
            2'd1:    be = 4'b0001 << lo;
            2'd2:    be = lo[1] ? 4'b1100 : 4'b0011;
            2'd3:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the unshifted store data so every enabled lane sees its bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] ops, input logic [31:0] wd);
        logic [31:0] lanes;
        case (ops)
            2'd1:    lanes = {4{wd[7:0]}};
            2'd2:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] w_data_r;
    logic [1:0]  st_ops_r;
    logic        st_r;
    logic        in_range_r;
    logic        ack_r;
    logic        err_r;
    logic [31:0] r_data_r;
    logic [31:0] mem_r [DEPTH];

    logic             req_s;
    logic             in_range_s;
    logic             commit_s;
    logic             we_s;
    logic             acc_st_s;
    logic             acc_in_range_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_w_data_s;
    logic [1:0]       acc_ops_s;
    logic [31:0]      off_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic [3:0]       be_s;
    logic [31:0]      lane_s;

    assign req_s      = dbus_ld_req_i | dbus_st_req_i;
    assign in_range_s = addr_in_range(dbus_addr_i);

    // Access source: live bus on a zero-wait capture, latched request otherwise
    always_comb begin
        acc_addr_s     = addr_r;
        acc_w_data_s   = w_data_r;
        acc_ops_s      = st_ops_r;
        acc_st_s       = st_r;
        acc_in_range_s = in_range_r;
        commit_s       = 1'b0;
        if (state_r == ST_IDLE) begin
            acc_addr_s     = dbus_addr_i;
            acc_w_data_s   = dbus_w_data_i;
            acc_ops_s      = dbus_st_ops_i;
            acc_st_s       = dbus_st_req_i;
            acc_in_range_s = in_range_s;
            commit_s       = req_s & NO_WAIT;
        end else if (state_r == ST_WAIT) begin
            commit_s = req_s & (cnt_r == 4'd1);
        end else begin
            commit_s = 1'b0;
        end
    end

    assign off_s     = acc_addr_s - BASE_ADDR;
    assign acc_idx_s = IDX_W'(off_s >> 2);
    assign be_s      = byte_en(acc_ops_s, acc_addr_s[1:0]);
    assign lane_s    = lane_data(acc_ops_s, acc_w_data_s);
    assign we_s      = commit_s & acc_st_s & acc_in_range_s & (acc_ops_s != 2'd0) & rst_n;

    // Request sequencing and the registered ack/err/read-data response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 32'h0;
            w_data_r   <= 32'h0;
            st_ops_r   <= 2'd0;
            st_r       <= 1'b0;
            in_range_r <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            r_data_r   <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        addr_r     <= dbus_addr_i;
                        w_data_r   <= dbus_w_data_i;
                        st_ops_r   <= dbus_st_ops_i;
                        st_r       <= dbus_st_req_i;
                        in_range_r <= in_range_s;
                        if (NO_WAIT) begin
                            state_r <= ST_ACK;
                            cnt_r   <= 4'd0;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WS_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r == 4'd1) begin
                        state_r <= ST_ACK;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
            // Read happens on the same edge as the write, so it returns the old word.
            if (commit_s) begin
                ack_r    <= 1'b1;
                err_r    <= ~acc_in_range_s;
                r_data_r <= acc_in_range_s ? mem_r[acc_idx_s] : 32'h0;
            end else begin
                ack_r    <= 1'b0;
                err_r    <= 1'b0;
                r_data_r <= 32'h0;
            end
        end
    end

    // Byte-lane writes into the data RAM
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[acc_idx_s][8*b +: 8] <= lane_s[8*b +: 8];
                end
            end
        end
    end

    assign dbus_ack_o    = ack_r;
    assign dbus_err_o    = err_r;
    assign dbus_r_data_o = r_data_r;

endmodule

// File: tb/tb_dbus_dmem_resp.sv
// Bench for dbus_dmem_resp: a zero-wait and a three-wait-state instance checked
// against a word-array reference model with directed and randomized accesses.
module tb_dbus_dmem_resp;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE1 = 32'h0000_2000;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ld    [2];
    logic        st    [2];
    logic [1:0]  ops   [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];

    logic [31:0] mem_m   [2][DEPTH];
    bit          valid_m [2][DEPTH];
    int          n_tests;
    int          n_fail;

    dbus_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .dbus_addr_i(addr[0]), .dbus_w_data_i(wdata[0]),
        .dbus_ld_req_i(ld[0]), .dbus_st_req_i(st[0]), .dbus_st_ops_i(ops[0]),
        .dbus_r_data_o(rdata[0]), .dbus_ack_o(ack[0]), .dbus_err_o(err[0])
    );

    dbus_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .dbus_addr_i(addr[1]), .dbus_w_data_i(wdata[1]),
        .dbus_ld_req_i(ld[1]), .dbus_st_req_i(st[1]), .dbus_st_ops_i(ops[1]),
        .dbus_r_data_o(rdata[1]), .dbus_ack_o(ack[1]), .dbus_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? BASE1 : 32'h0000_0000;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic bit m_in_range(input int d, input logic [31:0] a);
        longint unsigned aa;
        longint unsigned bb;
        aa = 64'(a);
        bb = 64'(base_of(d));
        return (aa >= bb) && (((aa - bb) / 4) < 64'(DEPTH));
    endfunction

    function automatic int m_idx(input int d, input logic [31:0] a);
        return int'((a - base_of(d)) / 32'd4);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [1:0] o,
                                            input logic [31:0] a, input logic [31:0] w);
        int          sh;
        logic [31:0] mask;
        case (o)
            2'd1: begin
                sh   = 8 * int'(a[1:0]);
                mask = 32'h0000_00FF << sh;
                return (old & ~mask) | ((w & 32'h0000_00FF) << sh);
            end
            2'd2: begin
                sh   = a[1] ? 16 : 0;
                mask = 32'h0000_FFFF << sh;
                return (old & ~mask) | ((w & 32'h0000_FFFF) << sh);
            end
            2'd3:    return w;
            default: return old;
        endcase
    endfunction

    // Full handshake on instance d: request held until ack, then dropped.
    // Entered and left at 1 time unit after a rising edge.
    task automatic access(input int d, input logic l, input logic s, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] w, output logic [31:0] rd_out);
        bit          inr;
        bit          known;
        int          idx;
        int          k;
        bit          got;
        logic        e;
        logic [31:0] exp_rd;
        inr    = m_in_range(d, a);
        idx    = inr ? m_idx(d, a) : 0;
        known  = inr ? valid_m[d][idx] : 1'b1;
        exp_rd = inr ? mem_m[d][idx] : 32'h0;
        addr[d] = a; wdata[d] = w; ops[d] = o; ld[d] = l; st[d] = s;
        got = 1'b0; k = 0; rd_out = 32'h0; e = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (ack[d] === 1'b1) begin
                got = 1'b1; rd_out = rdata[d]; e = err[d];
            end
        end
        ld[d] = 1'b0; st[d] = 1'b0; ops[d] = 2'd0;
        if (inr && s && o != 2'd0) begin
            mem_m[d][idx]   = m_merge(mem_m[d][idx], o, a, w);
            valid_m[d][idx] = 1'b1;
        end
        n_tests++;
        if (!got || k != ws_of(d) + 1) begin
            n_fail++;
            $display("FAIL latency d=%0d addr=%h got_ack=%0d cycles=%0d want=%0d", d, a, got, k, ws_of(d) + 1);
        end
        if (known) begin
            n_tests++;
            if (rd_out !== exp_rd) begin
                n_fail++;
                $display("FAIL r_data d=%0d addr=%h got=%h want=%h", d, a, rd_out, exp_rd);
            end
        end
        n_tests++;
        if (e !== !inr) begin
            n_fail++;
            $display("FAIL err d=%0d addr=%h got=%b want=%b", d, a, e, !inr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
            n_fail++;
            $display("FAIL after_ack d=%0d ack=%b err=%b r_data=%h want 0/0/0", d, ack[d], err[d], rdata[d]);
        end
    endtask

    // Store on the wait-state instance with request held for h edges, then dropped.
    task automatic abort_access(input logic [1:0] o, input logic [31:0] a, input logic [31:0] w, input int h);
        int acks;
        acks = 0;
        addr[1] = a; wdata[1] = w; ops[1] = o; st[1] = 1'b1; ld[1] = 1'b0;
        repeat (h) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        st[1] = 1'b0; ops[1] = 2'd0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL abort addr=%h hold=%0d acks=%0d want 0", a, h, acks);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset d=%0d ack=%b err=%b r_data=%h want 0/0/0", d, ack[d], err[d], rdata[d]);
            end
        end
    endtask

    task automatic test_init();
        logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                access(d, 1'b0, 1'b1, 2'd3, base_of(d) + 32'(4 * i), $urandom, rd);
            end
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd;
        access(0, 1'b0, 1'b1, 2'd3, 32'h10, 32'hDEAD_BEEF, rd);
        access(0, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, rd);
        check_word("lw_after_sw", rd, 32'hDEAD_BEEF);
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        access(0, 1'b0, 1'b1, 2'd3, 32'h10, 32'h1122_3344, rd);
        access(0, 1'b0, 1'b1, 2'd1, 32'h13, 32'h0000_00AA, rd);
        access(0, 1'b0, 1'b1, 2'd2, 32'h10, 32'h0000_1234, rd);
        access(0, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, rd);
        check_word("sb_sh_merge", rd, 32'hAA22_1234);
        access(1, 1'b0, 1'b1, 2'd2, BASE1 + 32'h32, 32'hFFFF_BEEF, rd);
        access(1, 1'b0, 1'b1, 2'd1, BASE1 + 32'h31, 32'h0000_0077, rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        access(1, 1'b0, 1'b1, 2'd3, BASE1 + 32'h20, 32'hCAFE_F00D, rd);
        access(1, 1'b1, 1'b0, 2'd0, BASE1 + 32'h20, 32'h0, rd);
        check_word("ws3_lw", rd, 32'hCAFE_F00D);
        access(1, 1'b1, 1'b0, 2'd0, BASE1 + 32'h24, 32'h0, rd);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        access(1, 1'b0, 1'b1, 2'd3, BASE1 + 32'h40, 32'h1234_5678, rd);
        abort_access(2'd3, BASE1 + 32'h40, 32'h0000_0055, 2);
        abort_access(2'd3, BASE1 + 32'h40, 32'h0000_0066, 3);
        abort_access(2'd1, BASE1 + 32'h41, 32'h0000_0077, 1);
        access(1, 1'b1, 1'b0, 2'd0, BASE1 + 32'h40, 32'h0, rd);
        check_word("after_abort", rd, 32'h1234_5678);
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic [31:0] w0;
        for (int d = 0; d < 2; d++) begin
            w0 = mem_m[d][0];
            access(d, 1'b1, 1'b0, 2'd0, base_of(d) + 32'(4 * DEPTH), 32'h0, rd);
            access(d, 1'b0, 1'b1, 2'd3, base_of(d) + 32'(4 * DEPTH), 32'hFFFF_FFFF, rd);
            access(d, 1'b1, 1'b0, 2'd0, base_of(d), 32'h0, rd);
            check_word("oor_no_write", rd, w0);
        end
        access(1, 1'b0, 1'b1, 2'd3, BASE1 - 32'd4, 32'h0BAD_0BAD, rd);
        access(1, 1'b1, 1'b0, 2'd0, BASE1 + 32'(4 * DEPTH - 4), 32'h0, rd);
    endtask

    task automatic test_amo();
        logic [31:0] rd;
        access(0, 1'b0, 1'b1, 2'd3, 32'h20, 32'h0000_0007, rd);
        access(0, 1'b1, 1'b1, 2'd3, 32'h20, 32'h0000_0005, rd);
        check_word("amo_old", rd, 32'h0000_0007);
        access(0, 1'b1, 1'b0, 2'd0, 32'h20, 32'h0, rd);
        check_word("amo_new", rd, 32'h0000_0005);
        access(0, 1'b0, 1'b1, 2'd0, 32'h20, 32'hABCD_0000, rd);
        access(0, 1'b1, 1'b0, 2'd0, 32'h20, 32'h0, rd);
        check_word("st_ops0_no_write", rd, 32'h0000_0005);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] keep;
        int          acks;
        keep = mem_m[1][17];
        acks = 0;
        addr[1] = BASE1 + 32'd68; wdata[1] = 32'h0000_0099; ops[1] = 2'd3; st[1] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        st[1] = 1'b0; ops[1] = 2'd0;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[1] === 1'b1) acks++;
        end
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ack acks=%0d want 0", acks);
        end
        access(1, 1'b1, 1'b0, 2'd0, BASE1 + 32'd68, 32'h0, rd);
        check_word("reset_mid_no_write", rd, keep);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] a;
        int          d;
        int          kind;
        logic        l;
        logic        s;
        repeat (300) begin
            d = int'($urandom_range(0, 1));
            if (d == 1 && $urandom_range(0, 7) == 0) begin
                abort_access(2'($urandom_range(1, 3)), BASE1 + 32'(4 * $urandom_range(0, DEPTH - 1)),
                             $urandom, int'($urandom_range(1, 3)));
            end else begin
                kind = int'($urandom_range(0, 2));
                l = (kind != 1);
                s = (kind != 0);
                if ($urandom_range(0, 9) == 0) begin
                    if (d == 1 && $urandom_range(0, 1) == 1) a = BASE1 - 32'(4 * $urandom_range(1, 16));
                    else a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
                end else begin
                    a = base_of(d) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                end
                access(d, l, s, 2'($urandom_range(0, 3)), a, $urandom, rd);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 32'h0; wdata[d] = 32'h0; ld[d] = 1'b0; st[d] = 1'b0; ops[d] = 2'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_init();
        test_sw_lw();
        test_subword();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_amo();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_dmem_resp.md
Name: dbus_dmem_resp

Overview:
- Data-bus responder: the memory-side end of the LSU data bus.
- Accepts load/store requests from the LSU and holds a word-organised data RAM.
- Performs byte, halfword and word writes from the store-op code.
- Returns the full aligned read word with a single-cycle ack after a configurable number of wait states; the LSU does sub-word extraction and sign extension.

Parameters:
- DEPTH, 4096: number of 32-bit words in the RAM.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_STATES, 0: extra cycles inserted between request capture and ack (0..15).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- dbus_addr_i  input  32  byte address from LSU.
- dbus_w_data_i  input  32  store data, unshifted (byte in [7:0], halfword in [15:0]).
- dbus_ld_req_i  input  1  load request; held until ack.
- dbus_st_req_i  input  1  store request; held until ack.
- dbus_st_ops_i  input  2  store size: 0=none, 1=SB, 2=SH, 3=SW.
- dbus_r_data_o  output  32  aligned read word; valid only while ack=1.
- dbus_ack_o  output  1  single-cycle completion pulse.
- dbus_err_o  output  1  pulses with ack when the address is out of range.

Behaviour:
- Reset (async assert, sync release): state=IDLE, wait counter=0, dbus_ack_o=0, dbus_err_o=0, dbus_r_data_o=0. RAM contents are not reset.
- req = dbus_ld_req_i | dbus_st_req_i.
- Word index = (dbus_addr_i - BASE_ADDR) >> 2.
  - in_range when dbus_addr_i >= BASE_ADDR and index < DEPTH.
  - Address bits [1:0] are ignored for word select.
- State machine: IDLE, WAIT, ACK.
  - IDLE: if req, latch addr, w_data, st_ops, ld/st flags and in_range. Go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else go to ACK.
  - WAIT: counter decrements each cycle. If req drops, abort to IDLE with no write and no ack (pipeline flush). When counter reaches 1 and req is still high, go to ACK.
  - ACK: dbus_ack_o=1 for exactly this cycle, with dbus_r_data_o and dbus_err_o registered and valid. Next state is always IDLE.
- Request-to-ack latency is WAIT_STATES+1 cycles after the IDLE capture edge. The minimum is one access per 2 cycles. A new request present in the cycle after ACK is captured normally (back-to-back).
- A request dropped in IDLE before capture has no effect. An abort is also honoured on the transition into ACK: if req is low in the final WAIT cycle, there is no ACK.
- Read: dbus_r_data_o = RAM[index], read on the ACK-transition edge. This is the pre-write value when a store targets the same word.
- Write: committed on the edge that enters ACK, only if st_req was latched, in_range, and st_ops != 0.
  - Byte enables:
    - SB: be = 1 << addr[1:0]; byte lane addr[1:0] gets w_data[7:0].
    - SH: be = addr[1] ? 4'b1100 : 4'b0011; lanes get w_data[15:0].
    - SW: be = 4'b1111.
  - A misaligned SH or SW is not checked here, because the LSU/CSR raise the misalignment trap. SH uses addr[1] only; SW ignores [1:0].
- ld_req and st_req both high: the access is treated as a store, and the read data still returns the old word. This supports AMO read-modify-write sequencing.
- st_req with st_ops=0: ack is given with no write.
- Out of range: ack is still given, dbus_err_o=1, dbus_r_data_o=0, and no write occurs.
- Reset asserted mid-access: the state machine returns to IDLE immediately, no pending write commits, and ack stays 0.
- Outside ACK, dbus_r_data_o holds 0 and dbus_err_o is 0.

Test Plan:
- WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF held until ack, then LW 0x10. Each ack arrives 1 cycle after capture; the load returns 0xDEADBEEF with err=0.
- SB 0x13 data 0x000000AA, then SH 0x10 data 0x00001234 over word 0x11223344 at 0x10. A following LW returns 0xAA221234.
- WAIT_STATES=3: LW issued and held. Ack arrives exactly 4 cycles after capture and is exactly 1 cycle wide. A second LW asserted the cycle after ack is captured and acked 4 cycles later.
- WAIT_STATES=3: SW data 0x55 with req dropped after 2 cycles. There is no ack, and a later LW of that word returns the original value (flush abort).
- LW at BASE_ADDR + 4*DEPTH: ack arrives with err=1 and r_data=0. An SW to the same address also gets ack with err=1 and leaves the RAM unchanged.
- ld_req and st_req both high, SW 0x5 to a word holding 0x7: ack r_data=0x7, then LW returns 0x5. Asserting rst_n low during WAIT gives no ack and no write.
